// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-channel memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    ABORT = 2'b10
  } arb_state_e;

  // Arbitration policy selector values.
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Memory direction encoding shared with the requesters.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Width of the per-grant watchdog counter. This is never narrower than
  // one bit, so the counter still exists when the watchdog is disabled.
  function automatic int cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_pick.sv
// Combinational one-hot picker: the first eligible channel found when
// scanning upward from a rotation base, wrapping modulo N.
module rr_priority_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] base,
  input  logic          mode,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx
);

  logic [IW-1:0] eff_base_s;
  logic          found_s;
  int            idx_s;

  // Scan from the effective base and take the first eligible channel.
  // Fixed mode always scans from channel 0.
  always_comb begin
    winner     = {N{1'b0}};
    winner_idx = {IW{1'b0}};
    found_s    = 1'b0;
    idx_s      = 0;
    if (mode == ARB_RR) begin
      eff_base_s = base;
    end else begin
      eff_base_s = {IW{1'b0}};
    end
    for (int off = 0; off < N; off++) begin
      idx_s = int'(eff_base_s) + off;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && elig[idx_s]) begin
        winner[idx_s] = 1'b1;
        winner_idx    = IW'(idx_s);
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory arbiter: grants the single memory port to one requester
// for a whole burst. Supports fixed-priority or round-robin selection, a
// per-grant watchdog abort, and write protection with per-channel exemption.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int               NUM_CH           = 3,
  parameter int               DATA_WIDTH       = 32,
  parameter int               ADDR_WIDTH       = 32,
  parameter int               ARB_MODE         = 0,
  parameter int               MAX_BURST_CYCLES = 64,
  parameter logic [NUM_CH-1:0] WP_EXEMPT       = {{(NUM_CH-1){1'b0}}, 1'b1}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         force_disable,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_rw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_write,
  input  logic [NUM_CH-1:0]            ch_op_size,
  input  logic [NUM_CH-1:0]            ch_finishes_op,
  output logic [NUM_CH-1:0]            ch_req_data,
  output logic [DATA_WIDTH-1:0]        ch_read,
  output logic [NUM_CH-1:0]            ch_read_valid,
  output logic [NUM_CH-1:0]            ch_last,
  output logic [NUM_CH-1:0]            grant,
  output logic                         timeout_err,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_enable,
  output logic                         mem_rw,
  output logic [DATA_WIDTH-1:0]        mem_write,
  output logic                         mem_op_size,
  output logic                         mem_finishes_op,
  input  logic                         mem_write_req_input,
  input  logic [DATA_WIDTH-1:0]        mem_read,
  input  logic                         mem_read_valid,
  input  logic                         mem_last
);

  localparam int            IW        = $clog2(NUM_CH);
  localparam int            CW        = cnt_width(MAX_BURST_CYCLES);
  localparam logic [CW-1:0] CNT_LIMIT = (MAX_BURST_CYCLES == 0) ? {CW{1'b0}}
                                                                : CW'(MAX_BURST_CYCLES - 1);
  localparam logic          WD_EN     = (MAX_BURST_CYCLES != 0);
  localparam logic          MODE      = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);

  arb_state_e        state_r, state_s;
  logic [NUM_CH-1:0] grant_r, grant_s;
  logic [IW-1:0]     gnt_idx_r, gnt_idx_s;
  logic [IW-1:0]     last_grant_r, last_grant_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [NUM_CH-1:0] elig_s;
  logic [IW-1:0]     rr_base_s;
  logic [NUM_CH-1:0] pick_onehot_s;
  logic [IW-1:0]     pick_idx_s;

  // A channel is eligible unless it wants to write while writes are blocked
  // and it holds no exemption.
  always_comb begin
    elig_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      elig_s[i] = ch_enable[i] &
                  ~(force_disable & (ch_rw[i] == MEM_WRITE) & ~WP_EXEMPT[i]);
    end
  end

  // The round-robin search starts one past the last grantee, wrapping.
  always_comb begin
    if (last_grant_r == LAST_IDX) begin
      rr_base_s = {IW{1'b0}};
    end else begin
      rr_base_s = last_grant_r + IW'(1);
    end
  end

  rr_priority_pick #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_pick (
    .elig       (elig_s),
    .base       (rr_base_s),
    .mode       (MODE),
    .winner     (pick_onehot_s),
    .winner_idx (pick_idx_s)
  );

  // Arbiter state registers. Reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= {NUM_CH{1'b0}};
      gnt_idx_r    <= {IW{1'b0}};
      last_grant_r <= LAST_IDX;
      cnt_r        <= {CW{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      gnt_idx_r    <= gnt_idx_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
    end
  end

  // Next-state logic: grant in IDLE, hold until mem_last or the watchdog
  // limit, and spend a single cycle in ABORT before returning to IDLE.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    gnt_idx_s    = gnt_idx_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    case (state_r)
      IDLE: begin
        if (|elig_s) begin
          state_s      = BUSY;
          grant_s      = pick_onehot_s;
          gnt_idx_s    = pick_idx_s;
          last_grant_s = pick_idx_s;
          cnt_s        = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_last) begin
          // Completion takes precedence over a watchdog hit in the same cycle.
          state_s = IDLE;
          grant_s = {NUM_CH{1'b0}};
          cnt_s   = {CW{1'b0}};
        end else if (WD_EN && (cnt_r == CNT_LIMIT)) begin
          state_s = ABORT;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ABORT: begin
        state_s = IDLE;
        grant_s = {NUM_CH{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
      default: begin
        state_s = IDLE;
        grant_s = {NUM_CH{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode: the memory command follows the grantee while BUSY, and
  // responses route back only to the grantee. ABORT signals the unwind.
  always_comb begin
    ch_read         = mem_read;
    grant           = grant_r;
    mem_enable      = 1'b0;
    mem_rw          = MEM_READ;
    mem_addr        = {ADDR_WIDTH{1'b0}};
    mem_write       = {DATA_WIDTH{1'b0}};
    mem_op_size     = 1'b0;
    mem_finishes_op = 1'b0;
    ch_req_data     = {NUM_CH{1'b0}};
    ch_read_valid   = {NUM_CH{1'b0}};
    ch_last         = {NUM_CH{1'b0}};
    timeout_err     = 1'b0;
    case (state_r)
      BUSY: begin
        mem_enable      = 1'b1;
        mem_addr        = ch_addr[int'(gnt_idx_r)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write       = ch_write[int'(gnt_idx_r)*DATA_WIDTH +: DATA_WIDTH];
        mem_rw          = ch_rw[gnt_idx_r];
        mem_op_size     = ch_op_size[gnt_idx_r];
        mem_finishes_op = ch_finishes_op[gnt_idx_r];
        ch_req_data     = grant_r & {NUM_CH{mem_write_req_input}};
        ch_read_valid   = grant_r & {NUM_CH{mem_read_valid}};
        ch_last         = grant_r & {NUM_CH{mem_last}};
      end
      ABORT: begin
        ch_last     = grant_r;
        timeout_err = 1'b1;
      end
      IDLE: begin
        mem_enable = 1'b0;
      end
      default: begin
        mem_enable = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed testbench for mem_arbiter_n: a fixed-priority instance with an
// 8-cycle watchdog and a round-robin instance share the same stimulus.
module tb_mem_arbiter_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        force_disable;
  logic [2:0]  ch_enable;
  logic [2:0]  ch_rw;
  logic [95:0] ch_addr;
  logic [95:0] ch_write;
  logic [2:0]  ch_op_size;
  logic [2:0]  ch_finishes_op;
  logic        mem_write_req_input;
  logic [31:0] mem_read;
  logic        mem_read_valid;
  logic        mem_last;

  logic [2:0]  f_ch_req_data, f_ch_read_valid, f_ch_last, f_grant;
  logic [31:0] f_ch_read, f_mem_addr, f_mem_write;
  logic        f_timeout_err, f_mem_enable, f_mem_rw, f_mem_op_size, f_mem_finishes_op;

  logic [2:0]  r_ch_req_data, r_ch_read_valid, r_ch_last, r_grant;
  logic [31:0] r_ch_read, r_mem_addr, r_mem_write;
  logic        r_timeout_err, r_mem_enable, r_mem_rw, r_mem_op_size, r_mem_finishes_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_n #(
    .NUM_CH(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(0),
    .MAX_BURST_CYCLES(8), .WP_EXEMPT(3'b001)
  ) dut_fix (
    .clk(clk), .rst_n(rst_n), .force_disable(force_disable),
    .ch_enable(ch_enable), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_write(ch_write),
    .ch_op_size(ch_op_size), .ch_finishes_op(ch_finishes_op),
    .ch_req_data(f_ch_req_data), .ch_read(f_ch_read), .ch_read_valid(f_ch_read_valid),
    .ch_last(f_ch_last), .grant(f_grant), .timeout_err(f_timeout_err),
    .mem_addr(f_mem_addr), .mem_enable(f_mem_enable), .mem_rw(f_mem_rw),
    .mem_write(f_mem_write), .mem_op_size(f_mem_op_size), .mem_finishes_op(f_mem_finishes_op),
    .mem_write_req_input(mem_write_req_input), .mem_read(mem_read),
    .mem_read_valid(mem_read_valid), .mem_last(mem_last)
  );

  mem_arbiter_n #(
    .NUM_CH(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(1),
    .MAX_BURST_CYCLES(64), .WP_EXEMPT(3'b001)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n), .force_disable(force_disable),
    .ch_enable(ch_enable), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_write(ch_write),
    .ch_op_size(ch_op_size), .ch_finishes_op(ch_finishes_op),
    .ch_req_data(r_ch_req_data), .ch_read(r_ch_read), .ch_read_valid(r_ch_read_valid),
    .ch_last(r_ch_last), .grant(r_grant), .timeout_err(r_timeout_err),
    .mem_addr(r_mem_addr), .mem_enable(r_mem_enable), .mem_rw(r_mem_rw),
    .mem_write(r_mem_write), .mem_op_size(r_mem_op_size), .mem_finishes_op(r_mem_finishes_op),
    .mem_write_req_input(mem_write_req_input), .mem_read(mem_read),
    .mem_read_valid(mem_read_valid), .mem_last(mem_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  exp_g;
    logic [31:0] exp_a;
    logic [31:0] exp_w;
    int          k;

    rst_n               = 1'b0;
    force_disable       = 1'b0;
    ch_enable           = 3'b000;
    ch_rw               = 3'b000;
    ch_addr             = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    ch_write            = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    ch_op_size          = 3'b010;
    ch_finishes_op      = 3'b100;
    mem_write_req_input = 1'b0;
    mem_read            = 32'h0000_0000;
    mem_read_valid      = 1'b0;
    mem_last            = 1'b0;

    // Reset state
    #12;
    chk("reset_grant", {61'd0, f_grant}, 64'd0);
    chk("reset_mem_enable", {63'd0, f_mem_enable}, 64'd0);
    chk("reset_mem_rw", {63'd0, f_mem_rw}, 64'd0);
    chk("reset_timeout", {63'd0, f_timeout_err}, 64'd0);
    chk("reset_ch_last", {61'd0, f_ch_last}, 64'd0);
    rst_n = 1'b1;

    // Fixed priority: ch1 and ch2 together, ch1 wins, then ch2
    ch_enable = 3'b110;
    cyc();
    chk("fix_grant_ch1", {61'd0, f_grant}, 64'd2);
    chk("fix_mem_enable", {63'd0, f_mem_enable}, 64'd1);
    chk("fix_mem_addr_ch1", {32'd0, f_mem_addr}, 64'h2000);
    chk("fix_op_size_ch1", {63'd0, f_mem_op_size}, 64'd1);
    chk("fix_finishes_ch1", {63'd0, f_mem_finishes_op}, 64'd0);
    chk("rr_first_grant_ch1", {61'd0, r_grant}, 64'd2);
    mem_last = 1'b1;
    #1;
    chk("fix_ch_last_ch1", {61'd0, f_ch_last}, 64'd2);
    cyc();
    mem_last  = 1'b0;
    ch_enable = 3'b100;
    chk("fix_bubble_grant", {61'd0, f_grant}, 64'd0);
    chk("fix_bubble_enable", {63'd0, f_mem_enable}, 64'd0);
    cyc();
    chk("fix_grant_ch2", {61'd0, f_grant}, 64'd4);
    chk("fix_mem_addr_ch2", {32'd0, f_mem_addr}, 64'h3000);
    chk("fix_finishes_ch2", {63'd0, f_mem_finishes_op}, 64'd1);
    mem_last  = 1'b1;
    ch_enable = 3'b000;
    cyc();
    mem_last = 1'b0;

    // Round robin: six 4-beat bursts with all channels requesting
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    ch_enable = 3'b111;
    for (int b = 0; b < 6; b++) begin
      k     = b % 3;
      exp_g = 3'b001 << k;
      exp_a = 32'h0000_1000 * 32'(k + 1);
      exp_w = (k == 0) ? 32'hDEAD_BEEF : ((k == 1) ? 32'h1111_1111 : 32'h2222_2222);
      cyc();
      chk($sformatf("rr_grant_b%0d", b), {61'd0, r_grant}, {61'd0, exp_g});
      chk($sformatf("rr_enable_b%0d", b), {63'd0, r_mem_enable}, 64'd1);
      chk($sformatf("rr_addr_b%0d", b), {32'd0, r_mem_addr}, {32'd0, exp_a});
      chk($sformatf("rr_wdata_b%0d", b), {32'd0, r_mem_write}, {32'd0, exp_w});
      cyc();
      cyc();
      cyc();
      chk($sformatf("rr_hold_b%0d", b), {61'd0, r_grant}, {61'd0, exp_g});
      mem_last = 1'b1;
      cyc();
      mem_last = 1'b0;
      chk($sformatf("rr_bubble_grant_b%0d", b), {61'd0, r_grant}, 64'd0);
      chk($sformatf("rr_bubble_enable_b%0d", b), {63'd0, r_mem_enable}, 64'd0);
    end
    ch_enable = 3'b000;

    // Write protection with ch0 exempt
    force_disable = 1'b1;
    ch_enable     = 3'b010;
    ch_rw         = 3'b010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("wp_ch1_write_blocked_%0d", i), {61'd0, f_grant}, 64'd0);
    end
    ch_rw = 3'b000;
    cyc();
    chk("wp_ch1_read_granted", {61'd0, f_grant}, 64'd2);
    mem_last  = 1'b1;
    ch_enable = 3'b000;
    cyc();
    mem_last = 1'b0;
    chk("wp_bubble_grant", {61'd0, f_grant}, 64'd0);
    ch_enable = 3'b001;
    ch_rw     = 3'b001;
    cyc();
    chk("wp_ch0_write_granted", {61'd0, f_grant}, 64'd1);
    chk("wp_ch0_mem_write", {32'd0, f_mem_write}, 64'hDEAD_BEEF);
    chk("wp_ch0_mem_rw", {63'd0, f_mem_rw}, 64'd1);
    mem_write_req_input = 1'b1;
    #1;
    chk("wp_ch0_req_data", {61'd0, f_ch_req_data}, 64'd1);
    mem_write_req_input = 1'b0;
    mem_last            = 1'b1;
    ch_enable           = 3'b000;
    ch_rw               = 3'b000;
    cyc();
    mem_last      = 1'b0;
    force_disable = 1'b0;

    // Watchdog: no mem_last, 8 BUSY cycles then one ABORT cycle
    ch_enable = 3'b001;
    cyc();
    chk("wd_grant", {61'd0, f_grant}, 64'd1);
    ch_enable = 3'b000;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("wd_busy_enable_c%0d", i), {63'd0, f_mem_enable}, 64'd1);
      chk($sformatf("wd_busy_timeout_c%0d", i), {63'd0, f_timeout_err}, 64'd0);
      cyc();
    end
    chk("wd_abort_timeout", {63'd0, f_timeout_err}, 64'd1);
    chk("wd_abort_ch_last", {61'd0, f_ch_last}, 64'd1);
    chk("wd_abort_enable", {63'd0, f_mem_enable}, 64'd0);
    cyc();
    chk("wd_after_timeout", {63'd0, f_timeout_err}, 64'd0);
    chk("wd_after_grant", {61'd0, f_grant}, 64'd0);
    chk("wd_after_ch_last", {61'd0, f_ch_last}, 64'd0);

    // mem_last in the limit cycle completes normally
    ch_enable = 3'b001;
    cyc();
    ch_enable = 3'b000;
    repeat (7) cyc();
    mem_last = 1'b1;
    cyc();
    mem_last = 1'b0;
    chk("wd_limit_last_no_err", {63'd0, f_timeout_err}, 64'd0);
    chk("wd_limit_last_grant", {61'd0, f_grant}, 64'd0);
    chk("wd_limit_last_enable", {63'd0, f_mem_enable}, 64'd0);

    // Asynchronous reset mid-burst
    ch_enable = 3'b100;
    cyc();
    chk("rst_pre_grant", {61'd0, f_grant}, 64'd4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_grant", {61'd0, f_grant}, 64'd0);
    chk("rst_async_enable", {63'd0, f_mem_enable}, 64'd0);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("rst_regrant", {61'd0, f_grant}, 64'd4);
    chk("rst_regrant_enable", {63'd0, f_mem_enable}, 64'd1);

    // Read routing to ch2
    mem_read       = 32'h1234_5678;
    mem_read_valid = 1'b1;
    #1;
    chk("rd_valid_route", {61'd0, f_ch_read_valid}, 64'd4);
    chk("rd_data_bcast", {32'd0, f_ch_read}, 64'h1234_5678);
    mem_read_valid = 1'b0;
    #1;
    chk("rd_valid_drop", {61'd0, f_ch_read_valid}, 64'd0);
    mem_last = 1'b1;
    #1;
    chk("rd_ch_last_ch2", {61'd0, f_ch_last}, 64'd4);
    ch_enable = 3'b000;
    cyc();
    mem_last = 1'b0;
    chk("rd_idle_ch_last", {61'd0, f_ch_last}, 64'd0);
    chk("rr_idle_outputs",
        {48'd0, r_ch_req_data, r_ch_read_valid, r_ch_last, r_grant,
         r_timeout_err, r_mem_enable, r_mem_rw, r_mem_op_size}, 64'd0);
    chk("rr_idle_finishes", {63'd0, r_mem_finishes_op}, 64'd0);
    chk("rr_read_bcast", {32'd0, r_ch_read}, 64'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
